csa_mult_seq: RTL and testbench

CSA_MULT_SEQ -- requirements
Module: csa_mult_seq

---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_row.sv | 22 ++
 rtl/csa_mult_seq.sv | 107 ++++++++++
 tb/tb_csa_mult_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-save multiplier: FSM states,
// default operand width and the bit-level compressor primitive.
package csa_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save compressor row: N independent full adders, no carry ripple.
module csa_row
  import csa_pkg::*;
#(
  parameter int unsigned N = 2 * W_DEFAULT
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  always_comb begin
    s = x ^ y ^ z;
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c[i] = maj3(x[i], y[i], z[i]);
    end
  end

endmodule

// File: rtl/csa_mult_seq.sv
// Sequential multiplier: one carry-save partial-product row per cycle for W
// cycles, then a single carry-propagate resolve into product.
module csa_mult_seq
  import csa_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W);

  state_t         state;
  logic [W2-1:0]  mcand;
  logic [W-1:0]   mplier;
  logic           sgn;
  logic           pend;
  logic [CW-1:0]  step;
  logic [W2-1:0]  sum_q;
  logic [W2-1:0]  carry_q;
  logic [W2-1:0]  pp;
  logic [W2-1:0]  row_s;
  logic [W2-1:0]  row_c;
  logic           last;

  // mcand/mplier are shifted each step so partial product i is always mcand gated by mplier[0]
  always_comb begin
    last = (step == CW'(W - 1));
    pp   = mplier[0] ? mcand : '0;
    if (sgn && last) begin
      pp = ~pp;
    end
  end

  csa_row #(.N(W2)) u_row (
    .x (sum_q),
    .y ({carry_q[W2-2:0], 1'b0}),
    .z (pp),
    .s (row_s),
    .c (row_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      sgn     <= 1'b0;
      pend    <= 1'b0;
      step    <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand   <= {{W{is_signed & a[W-1]}}, a};
            mplier  <= b;
            sgn     <= is_signed;
            pend    <= 1'b0;
            step    <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            busy    <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q   <= row_s;
          carry_q <= row_c;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          step    <= step + CW'(1);
          if (last) begin
            pend  <= sgn;
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          product <= sum_q + {carry_q[W2-2:0], 1'b0} + W2'(pend);
          state   <= DONE;
        end
        // done is registered, so the pulse is visible in the cycle after DONE
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mult_seq.sv
// Bench for csa_mult_seq at W=4 and W=8 against an integer-arithmetic product model.
module tb_csa_mult_seq;

  logic        clk;
  logic        rst;
  logic        start4, sg4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic        start8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int          n_cmp;
  int          n_err;
  logic [15:0] prev4;
  logic [15:0] prev8;

  csa_mult_seq #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .is_signed(sg4),
    .busy(busy4), .done(done4), .product(product4)
  );

  csa_mult_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .is_signed(sg8),
    .busy(busy8), .done(done8), .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] av, input logic [7:0] bv,
                                          input logic sg);
    longint x;
    longint y;
    longint p;
    x = longint'(av & 8'((1 << w) - 1));
    y = longint'(bv & 8'((1 << w) - 1));
    if (sg && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (sg && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    p = x * y;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] av, input logic [7:0] bv,
                       input logic sg);
    if (w == 4) begin
      start4 = st; a4 = av[3:0]; b4 = bv[3:0]; sg4 = sg;
    end else begin
      start8 = st; a8 = av; b8 = bv; sg8 = sg;
    end
  endtask

  function automatic logic dn(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic bsy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [15:0] prd(input int w);
    return (w == 4) ? {8'h00, product4} : product8;
  endfunction

  // start is held high for 'hold' cycles after acceptance; inputs are scrambled meanwhile
  task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic sg,
                       input int hold);
    logic [15:0] exp;
    logic [15:0] held;
    int          lat;
    exp  = ref_mul(w, av, bv, sg);
    held = (w == 4) ? prev4 : prev8;
    lat  = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv, sg);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      drive(w, n <= hold, 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      if (n == 1) check_eq("busy_running", 64'(bsy(w)), 64'd1);
      if (n == w) check_eq("product_hold", 64'(prd(w)), 64'(held));
      if (dn(w)) begin
        lat = n;
        break;
      end
    end
    check_eq("latency", 64'(lat), 64'(w + 2));
    check_eq("product", 64'(prd(w)), 64'(exp));
    check_eq("busy_at_done", 64'(bsy(w)), 64'd0);
    if (w == 4) prev4 = exp; else prev8 = exp;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    prev4 = '0;
    prev8 = '0;
    rst   = 1'b1;
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy4", 64'(busy4), 64'd0);
    check_eq("rst_done4", 64'(done4), 64'd0);
    check_eq("rst_prod4", 64'(product4), 64'd0);
    check_eq("rst_busy8", 64'(busy8), 64'd0);
    check_eq("rst_done8", 64'(done8), 64'd0);
    check_eq("rst_prod8", 64'(product8), 64'd0);
    rst = 1'b0;

    do_op(4, 8'd15, 8'd15, 1'b0, 0);
    do_op(4, 8'h8, 8'h8, 1'b1, 0);
    do_op(4, 8'hF, 8'h1, 1'b1, 0);

    // start held through busy and DONE must launch exactly one operation
    do_op(4, 8'd3, 8'd5, 1'b0, 6);
    @(negedge clk);
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("no_relaunch_done", 64'(done4), 64'd0);
      check_eq("no_relaunch_busy", 64'(busy4), 64'd0);
    end

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        do_op(4, 8'(i >> 4), 8'(i & 15), 1'(s), 0);
      end
    end

    do_op(8, 8'd0, 8'd0, 1'b0, 0);
    do_op(8, 8'd255, 8'd255, 1'b0, 0);
    do_op(8, 8'd255, 8'd255, 1'b1, 0);
    do_op(8, 8'd128, 8'd128, 1'b1, 0);
    do_op(8, 8'd128, 8'd127, 1'b1, 0);
    do_op(8, 8'd127, 8'd128, 1'b0, 0);
    for (int i = 0; i < 1500; i++) begin
      do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 0);
    end

    // asynchronous abort in the fourth ACCUM cycle
    do_op(8, 8'd200, 8'd77, 1'b0, 0);
    @(negedge clk);
    drive(8, 1'b1, 8'd99, 8'd55, 1'b0);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("abort_prod8", 64'(product8), 64'd0);
    check_eq("abort_busy8", 64'(busy8), 64'd0);
    check_eq("abort_done8", 64'(done8), 64'd0);
    check_eq("abort_prod4", 64'(product4), 64'd0);
    prev4 = '0;
    prev8 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("release_done8", 64'(done8), 64'd0);
    do_op(8, 8'd99, 8'd55, 1'b0, 0);
    do_op(8, 8'd156, 8'd201, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
